fpaddsub_arbiter: RTL and testbench
===================================

Name: fpaddsub_arbiter

Overview:
- Shares one combinational fpaddsub datapath (IEEE-style binary32 by default) between N_REQ independent requesters.
- Round-robin arbitration, a registered issue stage, and a registered result stage with valid/ready backpressure.
- Sits between the scalar FP issue ports and the single shared add/sub unit in the core.
- Sustains one operation per cycle; each result is tagged with the requester index.

Parameters:
N_REQ, 4, number of requesters (>= 2)
LOG_BIT, 5, log2 of operand width; passed to fpaddsub
EXP_BIT, 8, exponent width; passed to fpaddsub
N_BIT, 1 << LOG_BIT, operand width (derived)
ID_BIT, $clog2(N_REQ), requester-index width (derived)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  N_REQ  per-requester operation valid
req_ready  output  N_REQ  per-requester accept (one-hot or zero)
req_a  input  N_REQ*N_BIT  operand a; requester i at slice [i*N_BIT +: N_BIT]
req_b  input  N_REQ*N_BIT  operand b, same slicing
req_sub  input  N_REQ  1 = a-b, 0 = a+b; drives fpaddsub addnot_sub
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  ID_BIT  index of the requester that owns the result
rsp_result  output  N_BIT  fpaddsub output for that operation

Behaviour:
- Reset: all stage valids, rsp_valid, and the RR pointer ptr are cleared to 0; rsp_id and rsp_result are reset to 0. Reset mid-operation drops all in-flight ops; no response is produced for them.
- Pipeline state:
  - Stage A (issue reg): a_q, b_q, sub_q, ida_q, va.
  - fpaddsub sits combinationally between A and B.
  - Stage B (result reg): res_q, idb_q, vb. Outputs are rsp_valid=vb, rsp_id=idb_q, rsp_result=res_q, all driven straight from flops.
- Flow control:
  - adv_b = !vb || rsp_ready.
  - adv_a = !va || adv_b.
  - When adv_b: vb <= va, and res_q/idb_q load from the adder output and ida_q whenever va=1.
  - When adv_a: va <= |grant, and A loads the granted requester's operands.
  - When stalled, A and B hold their contents exactly.
- Arbitration:
  - Combinational. Search req_valid starting at index ptr, ascending, wrapping at N_REQ-1 -> 0; the first set bit wins.
  - grant is nonzero only if adv_a=1.
  - req_ready = grant, so req_ready may depend on req_valid.
  - On a transfer (req_valid[i] & req_ready[i]): ptr <= (i+1) mod N_REQ. Otherwise ptr holds.
- Requester contract: once req_valid is asserted, operands are held stable until accepted. The arbiter never retracts a grant within a cycle.
- Latency: op accepted at edge k -> rsp_valid=1 after edge k+1 (2 cycles). Throughput is 1 op/cycle with rsp_ready tied high.
- rsp_valid && !rsp_ready holds rsp_id and rsp_result stable; at most 2 ops are in flight.
- Simultaneous events:
  - rsp handshake and new grant in the same cycle are allowed; B and A both advance.
  - Empty A with stalled B still accepts one op; a further grant waits for adv_b.
- No internal FP processing: results (NaN, INF, zero, rounding) are exactly as fpaddsub produces them.

Optional Feature:
FPADDSUB_ARB_PERF_EN
- Defined:
  - Adds output perf_grants [N_REQ*16].
  - Each 16-bit counter increments on its requester's transfer, saturates at 0xFFFF, and is cleared by rst.
  - Adds output perf_stall [16], which counts cycles with rsp_valid && !rsp_ready, saturates at 0xFFFF, and is cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Single op: req0 a=0x3F800000, b=0x40000000, sub=0, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=0x40400000.
2. Subtract, lane 2: a=0x40400000, b=0x3F800000, sub=1 -> rsp_result=0x40000000, rsp_id=2.
3. Special values: req1 INF-INF (0x7F800000, 0x7F800000, sub=1) -> rsp_result=0x7FC00000, rsp_id=1.
4. Fairness: all 4 requesters held valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1…; one rsp per cycle; no requester waits more than 3 cycles.
5. Backpressure: 3 back-to-back ops from req3, rsp_ready=0 for 4 cycles.
   - Only 2 are accepted; req_ready=0 afterwards.
   - rsp_result stays stable while stalled.
   - After rsp_ready=1, all 3 results arrive in order with no loss or duplication.
6. Async reset mid-flight: assert rst between clock edges with va=vb=1 -> rsp_valid=0 and req_ready=0 immediately; ptr=0; no stale response after release; with FPADDSUB_ARB_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/fpaddsub_arbiter.sv
// Round-robin arbiter sharing one combinational binary32-style FP add/sub among N_REQ requesters.
// Define FPADDSUB_ARB_PERF_EN to add per-requester grant counters and a result-stall counter.

module fpaddsub #(
  parameter  int LOG_BIT = 5,
  parameter  int EXP_BIT = 8,
  localparam int N_BIT   = 1 << LOG_BIT
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             addnot_sub,
  output logic [N_BIT-1:0] result
);
  localparam int MAN_BIT = N_BIT - EXP_BIT - 1;
  localparam int SIG_BIT = MAN_BIT + 4;  // hidden + mantissa + guard/round/sticky
  localparam int EXP_MAX = (1 << EXP_BIT) - 1;

  logic               sa, sb, sx, sy, swap, eff_sub;
  logic [EXP_BIT-1:0] ea, eb, ex, ey;
  logic [MAN_BIT-1:0] ma, mb, mx, my;
  logic               any_nan, inf_clash, any_inf, round_up;
  logic [SIG_BIT-1:0] sig_x, sig_y, y_al, norm;
  logic [SIG_BIT:0]   sum;
  logic [N_BIT-2:0]   mag;
  int                 ex_i, ey_i, d, lz, exp_i;

  // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
  always_comb begin
    sa = a[N_BIT-1];
    ea = a[N_BIT-2 -: EXP_BIT];
    ma = a[MAN_BIT-1:0];
    sb = b[N_BIT-1] ^ addnot_sub;
    eb = b[N_BIT-2 -: EXP_BIT];
    mb = b[MAN_BIT-1:0];

    any_nan   = (&ea && |ma) || (&eb && |mb);
    inf_clash = &ea && !(|ma) && &eb && !(|mb) && (sa != sb);
    any_inf   = (&ea) || (&eb);

    // Larger magnitude becomes x so the aligned difference is never negative.
    swap = {eb, mb} > {ea, ma};
    sx   = swap ? sb : sa;
    sy   = swap ? sa : sb;
    ex   = swap ? eb : ea;
    mx   = swap ? mb : ma;
    ey   = swap ? ea : eb;
    my   = swap ? ma : mb;
    eff_sub = sx ^ sy;

    sig_x = {|ex, mx, 3'b000};
    sig_y = {|ey, my, 3'b000};
    ex_i  = (ex == '0) ? 1 : int'(ex);
    ey_i  = (ey == '0) ? 1 : int'(ey);
    d     = ex_i - ey_i;

    if (d >= SIG_BIT) begin
      y_al = {{(SIG_BIT-1){1'b0}}, |sig_y};
    end else begin
      y_al = sig_y >> d;
      if ((y_al << d) != sig_y) y_al[0] = 1'b1;
    end

    sum = eff_sub ? ({1'b0, sig_x} - {1'b0, y_al}) : ({1'b0, sig_x} + {1'b0, y_al});

    lz = SIG_BIT - 1;
    for (int i = 0; i < SIG_BIT; i++) begin
      if (sum[i]) lz = SIG_BIT - 1 - i;
    end

    // Left shifts stop at the minimum exponent, which yields subnormals naturally.
    if (sum[SIG_BIT]) begin
      norm    = sum[SIG_BIT:1];
      norm[0] = sum[1] | sum[0];
      exp_i   = ex_i + 1;
    end else if (lz < ex_i) begin
      norm  = sum[SIG_BIT-1:0] << lz;
      exp_i = ex_i - lz;
    end else begin
      norm  = sum[SIG_BIT-1:0] << (ex_i - 1);
      exp_i = 1;
    end

    // Round-to-nearest-even; a mantissa carry ripples into the exponent field.
    round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
    mag = {(norm[SIG_BIT-1] ? EXP_BIT'(exp_i) : EXP_BIT'(0)), norm[SIG_BIT-2:3]}
          + (N_BIT-1)'(round_up);

    if (any_nan || inf_clash)
      result = {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};
    else if (any_inf)
      result = {sx, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
    else if (sum == '0)
      result = {sx & !eff_sub, {(N_BIT-1){1'b0}}};
    else if (exp_i >= EXP_MAX)
      result = {sx, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
    else
      result = {sx, mag};
  end
endmodule

module fpaddsub_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int LOG_BIT = 5,
  parameter  int EXP_BIT = 8,
  localparam int N_BIT   = 1 << LOG_BIT,
  localparam int ID_BIT  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*N_BIT-1:0] req_a,
  input  logic [N_REQ*N_BIT-1:0] req_b,
  input  logic [N_REQ-1:0]       req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_BIT-1:0]      rsp_id,
  output logic [N_BIT-1:0]       rsp_result
`ifdef FPADDSUB_ARB_PERF_EN
  ,
  output logic [N_REQ*16-1:0]    perf_grants,
  output logic [15:0]            perf_stall
`endif
);
  logic [N_BIT-1:0]  a_q, b_q, sum_out, res_q;
  logic              sub_q, va, vb, adv_a, adv_b;
  logic [ID_BIT-1:0] ida_q, idb_q, ptr, gidx;
  logic [N_REQ-1:0]  grant;

  assign adv_b = !vb || rsp_ready;
  // Granting is suppressed while reset is held so no handshake can be lost.
  assign adv_a = (!va || adv_b) && !rst;

  always_comb begin
    int   j;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_valid[j] && adv_a) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gidx     = ID_BIT'(j);
      end
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      va    <= 1'b0;
      vb    <= 1'b0;
      idb_q <= '0;
      res_q <= '0;
    end else begin
      if (|grant) ptr <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
      if (adv_a) va <= |grant;
      if (adv_b) begin
        vb <= va;
        if (va) begin
          res_q <= sum_out;
          idb_q <= ida_q;
        end
      end
    end
  end

  // NOTE: issue-stage payload has no reset; it is only ever observed when va qualifies it.
  always_ff @(posedge clk) begin
    if (|grant) begin
      a_q   <= req_a[gidx*N_BIT +: N_BIT];
      b_q   <= req_b[gidx*N_BIT +: N_BIT];
      sub_q <= req_sub[gidx];
      ida_q <= gidx;
    end
  end

  fpaddsub #(
    .LOG_BIT (LOG_BIT),
    .EXP_BIT (EXP_BIT)
  ) u_fpaddsub (
    .a          (a_q),
    .b          (b_q),
    .addnot_sub (sub_q),
    .result     (sum_out)
  );

  assign rsp_valid  = vb;
  assign rsp_id     = idb_q;
  assign rsp_result = res_q;

`ifdef FPADDSUB_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && perf_grants[i*16 +: 16] != 16'hFFFF)
          perf_grants[i*16 +: 16] <= perf_grants[i*16 +: 16] + 16'd1;
      end
      if (vb && !rsp_ready && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// Directed self-checking bench for fpaddsub_arbiter (default build, 4 requesters, binary32).
module tb_fpaddsub_arbiter;
  localparam logic [31:0] ONE = 32'h3F800000;

  logic         clk, rst;
  logic [3:0]   req_valid, req_ready, req_sub;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;

  int n_tests = 0;
  int n_fail  = 0;

  fpaddsub_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_a[lane*32 +: 32] = a;
    req_b[lane*32 +: 32] = b;
    req_sub[lane]        = sub;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_sub = '0;
    #2;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'h0 || rsp_id !== 2'd0 || rsp_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b id=%0d result=%h, want 0 0000 0 00000000",
               rsp_valid, req_ready, rsp_id, rsp_result);
    end
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'h0;
    rst = 1'b0;
  endtask

  task automatic test_op(input string name, input int lane, input logic [31:0] a,
                         input logic [31:0] b, input logic sub, input logic [31:0] exp);
    @(negedge clk);
    rsp_ready = 1'b1;
    set_lane(lane, a, b, sub);
    req_valid = 4'(1 << lane);
    #1;
    n_tests++;
    if (req_ready !== req_valid) begin
      n_fail++;
      $display("FAIL %s_grant: ready=%b want %b", name, req_ready, req_valid);
    end
    @(negedge clk);
    req_valid = 4'h0;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: rsp_valid=%b want 0 one cycle after accept", name, rsp_valid);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'(lane) || rsp_result !== exp) begin
      n_fail++;
      $display("FAIL %s_rsp: valid=%b id=%0d result=%h, want 1 %0d %h",
               name, rsp_valid, rsp_id, rsp_result, lane, exp);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_dup: rsp_valid=%b want 0", name, rsp_valid);
    end
  endtask

  task automatic test_fairness();
    logic [31:0] ops  [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] exps [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, ops[i], ONE, 1'b0);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: ready=%b want %b", c, req_ready, 4'(1 << (c % 4)));
      end
      n_tests++;
      if (c < 2) begin
        if (rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_fill[%0d]: rsp_valid=%b want 0", c, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_result !== exps[(c - 2) % 4]) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: valid=%b id=%0d result=%h, want 1 %0d %h",
                 c, rsp_valid, rsp_id, rsp_result, (c - 2) % 4, exps[(c - 2) % 4]);
      end
      @(negedge clk);
    end
    req_valid = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] ops  [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    logic [31:0] exps [3] = '{32'h40000000, 32'h40400000, 32'h40800000};
    @(negedge clk);
    rsp_ready = 1'b0;
    set_lane(3, ops[0], ONE, 1'b0);
    req_valid = 4'b1000;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_accept0: ready=%b want 1000", req_ready);
    end
    @(negedge clk);
    set_lane(3, ops[1], ONE, 1'b0);
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_accept1: ready=%b want 1000", req_ready);
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      if (s == 0) set_lane(3, ops[2], ONE, 1'b0);
      #1;
      n_tests++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== exps[0]) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ready=%b valid=%b id=%0d result=%h, want 0000 1 3 %h",
                 s, req_ready, rsp_valid, rsp_id, rsp_result, exps[0]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (rsp_result !== exps[0]) begin
      n_fail++;
      $display("FAIL bp_stable: result=%h want %h", rsp_result, exps[0]);
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_release: ready=%b want 1000", req_ready);
    end
    for (int r = 1; r < 3; r++) begin
      @(negedge clk);
      req_valid = 4'h0;
      #1;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== exps[r]) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: valid=%b id=%0d result=%h, want 1 3 %h",
                 r, rsp_valid, rsp_id, rsp_result, exps[r]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_dup: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rsp_ready = 1'b0;
    set_lane(0, 32'h40000000, 32'h40000000, 1'b0);
    set_lane(1, ONE, ONE, 1'b0);
    set_lane(2, ONE, ONE, 1'b0);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL ar_prefill: valid=%b id=%0d ready=%b, want 1 1 1000", rsp_valid, rsp_id, req_ready);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'h0 || rsp_id !== 2'd0 || rsp_result !== 32'h0) begin
      n_fail++;
      $display("FAIL ar_immediate: valid=%b ready=%b id=%0d result=%h, want 0 0000 0 00000000",
               rsp_valid, req_ready, rsp_id, rsp_result);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'h0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ar_stale[%0d]: rsp_valid=%b want 0", s, rsp_valid);
      end
    end
    req_valid = 4'hF;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL ar_ptr: ready=%b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'h40800000) begin
      n_fail++;
      $display("FAIL ar_after: valid=%b id=%0d result=%h, want 1 0 40800000", rsp_valid, rsp_id, rsp_result);
    end
  endtask

  initial begin
    test_reset();
    test_op("add_lane0", 0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    test_op("sub_lane2", 2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);
    test_op("inf_minus_inf", 1, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    test_op("cancel_zero", 3, 32'h40400000, 32'h40400000, 1'b1, 32'h00000000);
    test_fairness();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
